// File: rtl/simple_out_uart.sv
// Captures 16-bit OUT words into a small FIFO and serialises each as two 8N1 UART bytes,
// high byte first.
module simple_out_uart #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  out_valid,
  input  logic [15:0]           out_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [CntW-1:0]     BaudLast = CntW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [15:0]           mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, overflow_q;
  logic                  push, pop;

  // Transmitter state
  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            byte_hi_q, byte_hi_d;
  logic [15:0]     word_q, word_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            baud_done;
  logic [7:0]      cur_byte;

  // full_q is the pre-edge value, so a write while full is dropped even if a pop coincides.
  assign push = out_valid & ~full_q;
  assign pop  = (state_q == StIdle) & (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= out_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      full_q     <= (count_d == DepthCnt);
      overflow_q <= overflow_q | (out_valid & full_q);
    end
  end

  assign baud_done = (baud_q == BaudLast);
  assign cur_byte  = byte_hi_q ? word_q[15:8] : word_q[7:0];

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    byte_hi_d = byte_hi_q;
    word_d    = word_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    case (state_q)
      StIdle: begin
        baud_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (count_q != '0) begin
          word_d    = mem_q[rd_ptr_q];
          byte_hi_d = 1'b1;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
          state_d   = StData;
        end
      end
      StData: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_d];
          end
        end
      end
      StStop: begin
        if (baud_done) begin
          baud_d = '0;
          if (byte_hi_q) begin
            // Low byte follows immediately with no idle gap.
            byte_hi_d = 1'b0;
            tx_d      = 1'b0;
            state_d   = StStart;
          end else begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      byte_hi_q <= 1'b0;
      word_q    <= 16'h0000;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      byte_hi_q <= byte_hi_d;
      word_q    <= word_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign level    = count_q;
  assign overflow = overflow_q;

endmodule

// File: doc/simple_out_uart.md
Name: simple_out_uart

Overview:
- Consumer end of the processor's OUT path: captures each 16-bit word the CPU emits on an OUT instruction and transmits it to a host as two 8N1 UART bytes, high byte first.
- Replaces the 7-seg readout as the way host-side test logs read program output.
- Contains a small FIFO so that OUT bursts do not stall or drop while the serial line drains.

Parameters:
- CLK_DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal values are 2 or greater.
- DEPTH_LOG2, 3, log2 of FIFO depth; default depth is 8 words.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous, active-high reset.
- out_valid, input, 1, one-cycle strobe from the CPU write-back stage when an OUT instruction retires.
- out_data, input, 16, word to send; sampled on the edge where out_valid=1.
- tx, output, 1, UART serial line; idles high.
- busy, output, 1, high while a word (2-byte frame pair) is being shifted.
- full, output, 1, FIFO holds 2^DEPTH_LOG2 words.
- level, output, DEPTH_LOG2+1, number of words currently queued; excludes the word being shifted.
- overflow, output, 1, sticky flag set when a write is dropped because the FIFO is full.

Behaviour:
- Reset (asynchronous, rst=1):
  - tx=1, busy=0, full=0, level=0, overflow=0.
  - FIFO pointers are zeroed, the FSM goes to IDLE, and the bit and baud counters are cleared.
  - Reset mid-frame aborts the frame immediately: tx returns high and the queue is discarded.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit read and write pointers that wrap modulo depth; level is the registered count.
  - Write is accepted on a clk edge when out_valid=1 and full=0 (the registered value before that edge).
  - If out_valid=1 and full=1, the word is dropped, overflow is set to 1, and it stays 1 until rst.
  - A write and a pop on the same edge: level is unchanged and both take effect.
  - A write while full with a simultaneous pop is still dropped, because full is evaluated before the pop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE, level≠0: pop the head word into the 16-bit shift register, set byte_sel=HI, tx<=0, busy<=1, then go to START.
  - IDLE, level=0: hold tx=1 and busy=0.
  - START: hold tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA:
    - Drive the current byte LSB first; each bit lasts CLK_DIV cycles.
    - After bit 7, go to STOP with tx=1.
  - STOP: hold tx=1 for CLK_DIV cycles, then:
    - if byte_sel=HI: set byte_sel=LO and go to START (tx<=0); the two bytes are back-to-back with no idle gap.
    - if byte_sel=LO: busy<=0 and go to IDLE.
    - IDLE always lasts at least 1 cycle between words.
- Timing:
  - tx falls on the first edge after the write edge when the FSM was idle, i.e. latency 1 cycle from the write to the start bit.
  - One word occupies exactly 20*CLK_DIV cycles of busy=1; back-to-back words repeat every 20*CLK_DIV+1 cycles.
- Byte order: high byte out_data[15:8] is sent first, then low byte [7:0].
- The baud counter runs 0..CLK_DIV-1 and is reset at every state entry.
- All outputs are registered; tx is glitch-free.

Test Plan:
- Reset idle: assert rst mid-simulation, release it, and hold 100 cycles -> tx=1, busy=0, level=0, full=0, overflow=0 throughout.
- Single word, CLK_DIV=4, out_data=16'hA53C pulsed once:
  - tx low 1 cycle later.
  - Decoded bitstream is 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1.
  - Each bit lasts 4 cycles; busy high for exactly 80 cycles, then level=0.
- Burst: 3 words (0x0001, 0x0002, 0x0003) on consecutive cycles with CLK_DIV=4:
  - level peaks at 2.
  - Bytes received are 00 01 00 02 00 03.
  - Start bits of consecutive words are 81 cycles apart.
- Full/overflow, DEPTH_LOG2=3:
  - Write 10 words back-to-back while the first is shifting -> full=1 after the 9th write.
  - The 10th write is dropped and overflow=1.
  - Host receives exactly the first 9 words in order.
- Simultaneous write and pop, and wrap-around:
  - Keep the FIFO at level=1 and issue a write on the pop edge -> level stays 1.
  - Run 20 words through -> pointers wrap and the data order is preserved.
- Reset mid-frame: assert rst during bit 3 of the high byte with 2 words queued:
  - tx=1, busy=0, level=0 immediately.
  - After release, a new word 0x1234 transmits correctly.
